// File: rtl/divider_pkg.sv
// Shared types for the non-restoring sequential divider: FSM state encoding
// and the iteration-counter width helper.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter holds DW-1 down to 0, so $clog2(DW) bits suffice for DW >= 2.
  function automatic int cnt_width(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/divider_nr_step.sv
// One combinational non-restoring iteration on a (VW+1)-bit two's-complement
// partial remainder; with fix_i set it performs the final corrective add instead.
module divider_nr_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          a_msb_i,
  input  logic [VW-1:0] b_i,
  input  logic          fix_i,
  output logic [VW:0]   r_o,
  output logic          q_o
);

  logic [VW:0] opnd;
  logic [VW:0] b_ext;
  logic        add;

  // The shifted remainder may wrap in VW+1 bits, but the result always lands
  // back in [-B, B), so modular arithmetic gives the exact value.
  always_comb begin
    b_ext = {1'b0, b_i};
    opnd  = fix_i ? r_i : {r_i[VW-1:0], a_msb_i};
    add   = fix_i | r_i[VW];
    r_o   = add ? (opnd + b_ext) : (opnd - b_ext);
    // With B=0 the true remainder never goes negative; the sign bit only
    // reflects wrap-around, so the quotient bit is forced to 1.
    q_o   = ~r_o[VW] | (b_i == '0);
  end

endmodule

// File: rtl/divider_nr_seq.sv
// Iterative non-restoring unsigned divider, one quotient bit per clock.
// Optional divide-by-zero short-cut enabled by defining DIVIDER_DBZ_EN.
module divider_nr_seq
  import divider_pkg::*;
#(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output state_e        dbg_state
);

  localparam int CW = cnt_width(DW);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and stays
  // high with stable data until out_ready is seen (or reset).
  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [VW-1:0] b_q, b_d;
  logic [VW:0]   r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   step_r;
  logic          step_q;
  logic          accept;

`ifdef DIVIDER_DBZ_EN
  logic dbz_q, dbz_d;
  logic b_zero;
  assign b_zero = (divisor == '0);
`endif

  assign accept = in_valid && in_ready;

  divider_nr_step #(.VW(VW)) u_step (
    .r_i     (r_q),
    .a_msb_i (a_q[DW-1]),
    .b_i     (b_q),
    .fix_i   (state_q == FIX),
    .r_o     (step_r),
    .q_o     (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIVIDER_DBZ_EN
          state_d = b_zero ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    quotient  = a_q;
    remainder = r_q[VW-1:0];
    dbg_state = state_q;
`ifdef DIVIDER_DBZ_EN
    dbz       = dbz_q;
`else
    dbz       = 1'b0;
`endif
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    r_d   = r_q;
    cnt_d = cnt_q;
`ifdef DIVIDER_DBZ_EN
    dbz_d = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = dividend;
          b_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(DW - 1);
`ifdef DIVIDER_DBZ_EN
          dbz_d = 1'b0;
          if (b_zero) begin
            a_d   = '1;
            r_d   = {1'b0, dividend[VW-1:0]};
            dbz_d = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        r_d   = step_r;
        a_d   = {a_q[DW-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        if (r_q[VW]) r_d = step_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef DIVIDER_DBZ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
`endif

endmodule

// File: tb/tb_divider_nr_seq.sv
// Bench for divider_nr_seq: table-driven vectors through a scoreboard, plus
// directed backpressure, mid-calculation reset and DW=4/VW=2 latency sequences.
module tb_divider_nr_seq;
  import divider_pkg::*;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int W  = DW + VW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, dbz;
  logic [DW-1:0] dividend, quotient;
  logic [VW-1:0] divisor, remainder;
  state_e        dbg_state;

  logic          in_valid4, in_ready4, out_valid4, out_ready4, dbz4;
  logic [3:0]    dividend4, quotient4;
  logic [1:0]    divisor4, remainder4;
  state_e        dbg_state4;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  always #5 clk = ~clk;

  divider_nr_seq #(.DW(DW), .VW(VW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .dbz(dbz), .dbg_state(dbg_state)
  );

  divider_nr_seq #(.DW(4), .VW(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .dividend(dividend4), .divisor(divisor4), .out_valid(out_valid4),
    .out_ready(out_ready4), .quotient(quotient4), .remainder(remainder4),
    .dbz(dbz4), .dbg_state(dbg_state4)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    if (b == '0) begin
`ifdef DIVIDER_DBZ_EN
      return {{DW{1'b1}}, a[VW-1:0], 1'b1};
`else
      return {{DW{1'b1}}, a[VW-1:0], 1'b0};
`endif
    end
    q = a / DW'(b);
    r = a % DW'(b);
    return {q, r[VW-1:0], 1'b0};
  endfunction

  // Scoreboard: every result handshake pops one expected record.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("quotient", 32'(quotient), 32'(exp_e[W-1:VW+1]));
        check("remainder", 32'(remainder), 32'(exp_e[VW:1]));
        check("dbz", 32'(dbz), 32'(exp_e[0]));
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(a, b));
  endtask

  task automatic wait_done(input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    int n;

    vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4};
    vecs[1] = '{a: 8'd5,   b: 4'd9,  q: 8'd0,   r: 4'd5};
    vecs[2] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0};
    vecs[3] = '{a: 8'd0,   b: 4'd15, q: 8'd0,   r: 4'd0};
    vecs[4] = '{a: 8'd13,  b: 4'd3,  q: 8'd4,   r: 4'd1};
    vecs[5] = '{a: 8'd100, b: 4'd10, q: 8'd10,  r: 4'd0};

    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; dividend4 = '0; divisor4 = '0; out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b);
      // Table expectations override the generic model push for these rows.
      exp_q[exp_q.size()-1] = {vecs[i].q, vecs[i].r, 1'b0};
      wait_done(DW + 2);
    end

`ifdef DIVIDER_DBZ_EN
    send(8'hA5, 4'd0);
    wait_done(1);
`else
    send(8'hA5, 4'd0);
    wait_done(DW + 2);
`endif
    send(8'd200, 4'd7);
    wait_done(DW + 2);

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(1, 15));
      send(ra, rb);
      wait_done(DW + 2);
    end

    // Backpressure: hold the result for 20 cycles while poking in_valid.
    out_ready = 1'b0;
    send(8'd200, 4'd7);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("bp_latency", 32'(n), 32'(DW + 2));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'd28);
      check("bp_remainder", 32'(remainder), 32'd4);
      @(posedge clk); #1;
      in_valid = k[0];
      dividend = 8'd99;
      divisor  = 4'd3;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    repeat (12) @(negedge clk);
    check("bp_no_stray_output", 32'(out_valid), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of the third CALC iteration.
    send(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd13, 4'd3);
    wait_done(DW + 2);
    repeat (12) @(negedge clk);
    check("midrst_no_stray_output", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // DW=4, VW=2 instance: 13 / 3.
    check("dw4_in_ready", 32'(in_ready4), 32'd1);
    dividend4 = 4'd13;
    divisor4  = 2'd3;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid4 && n < 20);
    check("dw4_latency", 32'(n), 32'd6);
    check("dw4_quotient", 32'(quotient4), 32'd4);
    check("dw4_remainder", 32'(remainder4), 32'd1);
    check("dw4_dbz", 32'(dbz4), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("dw4_back_idle", 32'(in_ready4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
